// File: rtl/nukv_stream_pkg.sv
// rtl/nukv_stream_pkg.sv - shared keep codes, pack state enum and width helper for nukv stream stages
package nukv_stream_pkg;

    localparam logic [1:0] KEEP_FULL = 2'b11;
    localparam logic [1:0] KEEP_LO   = 2'b01;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } pack_state_t;

    function automatic int pack2_width(input int data_size);
        return 2 * data_size;
    endfunction

endpackage

// File: rtl/nukv_idle_timer.sv
// rtl/nukv_idle_timer.sv - saturating idle counter with clear/enable and a compare-hit output
module nukv_idle_timer #(
    parameter int TIMEOUT_BITS = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_hit
);

    localparam logic [TIMEOUT_BITS-1:0] LIMIT = TIMEOUT_BITS'(TIMEOUT);

    logic [TIMEOUT_BITS-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A zero limit disables the timeout entirely rather than firing immediately.
    assign o_hit = (TIMEOUT != 0) && (r_count == LIMIT);

endmodule

// File: rtl/nukv_stream_pack2.sv
// rtl/nukv_stream_pack2.sv - packs pairs of input beats into one double-width word, low half first
module nukv_stream_pack2
    import nukv_stream_pkg::*;
#(
    parameter int DATA_SIZE    = 16,
    parameter int TIMEOUT_BITS = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic [DATA_SIZE-1:0]                s_axis_tdata,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    output logic                                s_axis_talmostfull,
    output logic [pack2_width(DATA_SIZE)-1:0]   m_axis_tdata,
    output logic [1:0]                          m_axis_tkeep,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready
);

    localparam int OUT_W = pack2_width(DATA_SIZE);

    pack_state_t            r_state;
    pack_state_t            w_state_nxt;
    logic [DATA_SIZE-1:0]   r_lo;
    logic                   r_flush_pend;
    logic                   r_out_valid;
    logic [OUT_W-1:0]       r_out_data;
    logic [1:0]             r_out_keep;

    logic                   w_slot_free;
    logic                   w_beat;
    logic                   w_pair;
    logic                   w_emit_half;
    logic                   w_flush_req;
    logic                   w_timer_hit;
    logic                   w_timer_clear;
    logic                   w_timer_en;

    // The output slot counts as free when it is empty or being drained this cycle.
    assign w_slot_free   = !r_out_valid || m_axis_tready;
    assign s_axis_tready = rst_n && ((r_state == S_EMPTY) || w_slot_free);
    assign w_beat        = s_axis_tvalid && s_axis_tready;
    assign w_flush_req   = r_flush_pend || flush;

    always_comb begin
        w_state_nxt = r_state;
        w_pair      = 1'b0;
        w_emit_half = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_beat) begin
                    w_state_nxt = S_HALF;
                end
            end
            S_HALF: begin
                // A second beat always beats a timeout or flush to the slot.
                if (w_beat) begin
                    w_pair      = 1'b1;
                    w_state_nxt = S_EMPTY;
                end else if ((w_timer_hit || w_flush_req) && w_slot_free) begin
                    w_emit_half = 1'b1;
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lo <= '0;
        end else if ((r_state == S_EMPTY) && w_beat) begin
            r_lo <= s_axis_tdata;
        end
    end

    // Flush is remembered only while a half word exists or is arriving this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flush_pend <= 1'b0;
        end else if (w_pair || w_emit_half) begin
            r_flush_pend <= 1'b0;
        end else if (flush && ((r_state == S_HALF) || w_beat)) begin
            r_flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
        end else if (w_pair) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {s_axis_tdata, r_lo};
            r_out_keep  <= KEEP_FULL;
        end else if (w_emit_half) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {{DATA_SIZE{1'b0}}, r_lo};
            r_out_keep  <= KEEP_LO;
        end else if (r_out_valid && m_axis_tready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign w_timer_clear = w_beat || (r_state == S_EMPTY) || w_emit_half;
    assign w_timer_en    = (r_state == S_HALF) && !w_beat;

    nukv_idle_timer #(
        .TIMEOUT_BITS (TIMEOUT_BITS),
        .TIMEOUT      (TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_hit    (w_timer_hit)
    );

    assign m_axis_tvalid      = r_out_valid;
    assign m_axis_tdata       = r_out_data;
    assign m_axis_tkeep       = r_out_keep;
    assign s_axis_talmostfull = rst_n && (r_state == S_HALF) && r_out_valid && !m_axis_tready;

endmodule
